// File: rtl/pipelined_adder.sv
// Ripple-carry adder/subtractor split into STAGES slice-wide pipeline stages
// with a valid/ready handshake; the whole pipeline freezes when the output stalls.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            c_q, c_d, c_in;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in;
  logic [STAGES-1:0][SLICE:0]   slc;
  logic                         ovf_q, ovf_d;
  logic                         stall;

  assign stall    = vld_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    // stage 0 sees the effective operands: subtract folds into ~b with carry-in 1
    a_in[0]  = a;
    b_in[0]  = sub ? ~b : b;
    c_in[0]  = sub | cin;
    s_in[0]  = '0;
    vld_d[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]  = a_q[k-1];
      b_in[k]  = b_q[k-1];
      c_in[k]  = c_q[k-1];
      s_in[k]  = s_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slc[k] = {1'b0, a_in[k][k*SLICE +: SLICE]} + {1'b0, b_in[k][k*SLICE +: SLICE]}
             + {{SLICE{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*SLICE +: SLICE] = slc[k][SLICE-1:0];
      c_d[k] = slc[k][SLICE];
    end
    a_d   = a_in;
    b_d   = b_in;
    ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
            (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder against an integer-arithmetic
// model; results are matched in acceptance order through a queue.
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub;
  logic         out_valid, cout, ovf;
  logic         out_ready = 1'b1;
  bit           rdy_rand = 1'b0;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [33:0]  exp_q[$];
  int           obs_cyc[$];
  logic [31:0]  obs_sum[$];
  logic [33:0]  e, prev_res;
  bit           prev_stall;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always begin
    @(posedge clk); #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain signed/unsigned arithmetic
  function automatic logic [33:0] model(input logic [31:0] ma, mb, input logic mc, ms);
    longint unsigned ua, ub, u;
    longint sa, sb, s;
    logic co, ov;
    ua = longint'(ma); ub = longint'(mb);
    sa = longint'($signed(ma)); sb = longint'($signed(mb));
    if (ms) begin
      u = ua - ub; co = (ua >= ub); s = sa - sb;
    end else begin
      u = ua + ub + longint'(mc); co = u[32]; s = sa + sb + longint'(mc);
    end
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ov, co, u[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_res", {ovf, cout, sum}, prev_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("result", {ovf, cout, sum}, e);
          obs_cyc.push_back(cyc);
          obs_sum.push_back(sum);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      prev_stall = out_valid && !out_ready;
      prev_res   = {ovf, cout, sum};
    end
  end

  task automatic send(input logic [31:0] ta, tb, input logic tc, ts);
    bit ok = 1'b0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    chk("send_timeout", ok, 1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // idle pipeline, out_ready=1: result must appear exactly S cycles later
  task automatic dir(input string t, input logic [31:0] ta, tb, input logic tc, ts,
                     input logic [31:0] es, input logic ec, eo);
    int n;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({t, "_lat"}, n, S);
    chk({t, "_sum"}, sum, es);
    chk({t, "_cout"}, cout, ec);
    chk({t, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic stream(input bit rnd);
    obs_cyc.delete(); obs_sum.delete();
    rdy_rand = rnd;
    for (int i = 0; i < 8; i++) send(32'(i), 32'(1000 * i), 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    rdy_rand = 1'b0;
    chk("stream_n", obs_sum.size(), 8);
    for (int i = 0; i < obs_sum.size() && i < 8; i++) begin
      chk("stream_sum", obs_sum[i], 1001 * i);
      if (!rnd && i > 0) chk("stream_b2b", obs_cyc[i] - obs_cyc[i-1], 1);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_res", {ovf, cout, sum}, 0);
    rst = 1'b0;

    dir("add",    32'd1209, 32'd4565, 1'b0, 1'b0, 32'd5774, 1'b0, 1'b0);
    dir("wrap",   32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    dir("ovf",    32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    dir("sub",    32'd17, 32'd3, 1'b0, 1'b1, 32'd14, 1'b1, 1'b0);
    dir("subneg", 32'd3, 32'd17, 1'b1, 1'b1, 32'hFFFF_FFF2, 1'b0, 1'b0);
    dir("cin",    32'd5, 32'd6, 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);

    stream(1'b0);
    stream(1'b1);

    // three operations in flight, then a one-cycle reset pulse
    send(32'd1, 32'd2, 1'b0, 1'b0);
    send(32'd3, 32'd4, 1'b0, 1'b0);
    send(32'd5, 32'd6, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1; #1;
    chk("rstmid_vld", out_valid, 0);
    chk("rstmid_res", {ovf, cout, sum}, 0);
    chk("rstmid_rdy", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    dir("r300", 32'd100, 32'd200, 1'b0, 1'b0, 32'd300, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    wait_drain();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
